// File: rtl/aes_mixcol_seq_if.sv
// aes_mixcol_seq_if: valid/ready state-word bus around the MixColumns stage.
// The in_inv select exists only when MIXCOL_INV_EN is defined.
interface aes_mixcol_seq_if;
   logic in_valid, in_ready, in_last, out_valid, out_ready;
   logic [127:0] in_data, out_data;
`ifdef MIXCOL_INV_EN
   logic in_inv;
   modport master (output in_valid, in_data, in_last, in_inv, out_ready, input in_ready, out_valid, out_data);
   modport slave (input in_valid, in_data, in_last, in_inv, out_ready, output in_ready, out_valid, out_data);
`else
   modport master (output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_data);
   modport slave (input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/aes_mixcol_seq.sv
// aes_mixcol_seq: sequential AES MixColumns, one column per clock, with final-round bypass.
// Defining MIXCOL_INV_EN adds an in_inv select for InvMixColumns.
module aes_mixcol_seq #(
   parameter int COLS = 4
) (
   input logic clk,
   input logic rst,
   aes_mixcol_seq_if.slave bus
);
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, nxt;
   logic [127:0] work, od;
   logic [CW-1:0] col;
   logic acc;
   logic [31:0] cur, mix;
`ifdef MIXCOL_INV_EN
   logic inv;
`endif
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xt(b);
      x4 = xt(x2);
      x8 = xt(x4);
      return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
   endfunction
   // nibble j of k multiplies byte (i+j)%4 when producing output row i
   function automatic logic [31:0] mixcol(input logic [31:0] c, input logic [15:0] k);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            r[31-8*i -: 8] = r[31-8*i -: 8] ^ gm(c[31-8*((i+j)%4) -: 8], k[15-4*j -: 4]);
      return r;
   endfunction
   assign cur = work[127-32*col -: 32];
`ifdef MIXCOL_INV_EN
   assign mix = inv ? mixcol(cur, 16'hebd9) : mixcol(cur, 16'h2311);
`else
   assign mix = mixcol(cur, 16'h2311);
`endif
   assign bus.in_ready = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_data = od;
   assign acc = bus.in_valid & (state == IDLE);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      if (state == IDLE && acc) nxt = bus.in_last ? DONE : CALC;
      if (state == CALC && col == CW'(COLS-1)) nxt = DONE;
      if (state == DONE && bus.out_ready) nxt = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         work <= '0;
         od <= '0;
         col <= '0;
`ifdef MIXCOL_INV_EN
         inv <= 1'b0;
`endif
      end else if (acc) begin
         work <= bus.in_data;
         col <= '0;
`ifdef MIXCOL_INV_EN
         inv <= bus.in_inv;
`endif
         if (bus.in_last) od <= bus.in_data;
      end else if (state == CALC) begin
         od[127-32*col -: 32] <= mix;
         col <= (col == CW'(COLS-1)) ? '0 : col + 1'b1;
      end
endmodule

// File: tb/tb_aes_mixcol_seq.sv
// tb_aes_mixcol_seq: scoreboard bench for aes_mixcol_seq (FIPS-197 vectors, bypass, backpressure, reset).
// Inverse scenarios are compiled in when MIXCOL_INV_EN is defined.
module tb_aes_mixcol_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   aes_mixcol_seq_if bus();
   aes_mixcol_seq #(.COLS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   int n_cmp = 0;
   int n_err = 0;
   logic [127:0] exp_q[$];
   localparam logic [127:0] V1_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
   localparam logic [127:0] V1_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
   localparam logic [127:0] V2_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] V2_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] V3     = 128'h000102030405060708090a0b0c0d0e0f;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d, input logic last, input logic inv);
      logic [7:0] cf [4];
      logic [7:0] s;
      logic [127:0] r;
      if (last) return d;
      cf = inv ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int o = 0; o < 4; o++) begin
            s = 8'h00;
            for (int j = 0; j < 4; j++) s = s ^ gmul(cf[(j - o + 4) % 4], d[127-32*c-8*j -: 8]);
            r[127-32*c-8*o -: 8] = s;
         end
      return r;
   endfunction

   task automatic send(input logic [127:0] d, input logic last, input logic inv, input logic [127:0] expv, output bit ok);
      int k;
      bus.in_valid = 1'b1;
      bus.in_data = d;
      bus.in_last = last;
`ifdef MIXCOL_INV_EN
      bus.in_inv = inv;
`endif
      k = 0;
      while (!bus.in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      ok = (bus.in_ready === 1'b1);
      @(posedge clk);
      exp_q.push_back(expv);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.in_last = 1'b0;
      bus.out_ready = 1'b1;
`ifdef MIXCOL_INV_EN
      bus.in_inv = 1'b0;
`endif
      @(posedge clk); #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fips_cols();
      bit ok;
      int cyc;
      logic [127:0] e;
      send(V1_IN, 1'b0, 1'b0, V1_OUT, ok);
      wait_out(cyc);
      n_cmp++; if (!ok || cyc != 4) begin n_err++; $display("FAIL cols_latency: got %0d (acc %0b) want 4", cyc, ok); end
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      n_cmp++; if (bus.out_data !== e) begin n_err++; $display("FAIL cols_data: got %h want %h", bus.out_data, e); end
      @(posedge clk); #1;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL cols_one_cycle: got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); end
   endtask

   task automatic test_round1();
      bit ok;
      int cyc;
      logic [127:0] e;
      send(V2_IN, 1'b0, 1'b0, V2_OUT, ok);
      wait_out(cyc);
      n_cmp++; if (!ok || cyc != 4) begin n_err++; $display("FAIL round1_latency: got %0d want 4", cyc); end
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      n_cmp++; if (bus.out_data !== e) begin n_err++; $display("FAIL round1_data: got %h want %h", bus.out_data, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_bypass();
      bit ok;
      int cyc;
      logic [127:0] e;
      send(V3, 1'b1, 1'b0, V3, ok);
      wait_out(cyc);
      n_cmp++; if (!ok || cyc != 0) begin n_err++; $display("FAIL bypass_latency: got %0d want 0", cyc); end
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      n_cmp++; if (bus.out_data !== e) begin n_err++; $display("FAIL bypass_data: got %h want %h", bus.out_data, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      bit ok;
      int cyc;
      logic [127:0] ea, e;
      bus.out_ready = 1'b0;
      send(V1_IN, 1'b0, 1'b0, V1_OUT, ok);
      wait_out(cyc);
      ea = exp_q.size() ? exp_q.pop_front() : 'x;
      n_cmp++; if (!ok || cyc != 4 || bus.out_data !== ea) begin n_err++; $display("FAIL bp_first: got %h lat %0d want %h lat 4", bus.out_data, cyc, ea); end
      bus.in_valid = 1'b1;
      bus.in_data = V2_IN;
      bus.in_last = 1'b0;
      exp_q.push_back(V2_OUT);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== ea) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: got valid %b ready %b data %h want 1 0 %h", i, bus.out_valid, bus.in_ready, bus.out_data, ea);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle: got ready %b valid %b want 1 0", bus.in_ready, bus.out_valid); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_accept: got ready %b want 0", bus.in_ready); end
      wait_out(cyc);
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      n_cmp++; if (cyc != 4 || bus.out_data !== e) begin n_err++; $display("FAIL bp_second: got %h lat %0d want %h lat 4", bus.out_data, cyc, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      bit ok;
      int cyc;
      logic [127:0] e;
      send(V1_IN, 1'b0, 1'b0, V1_OUT, ok);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 128'h0) begin
         n_err++;
         $display("FAIL async_reset: got valid %b ready %b data %h want 0 1 0", bus.out_valid, bus.in_ready, bus.out_data);
      end
      exp_q.delete();
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      send(V1_IN, 1'b0, 1'b0, V1_OUT, ok);
      wait_out(cyc);
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      n_cmp++; if (!ok || cyc != 4 || bus.out_data !== e) begin n_err++; $display("FAIL post_reset: got %h lat %0d want %h lat 4", bus.out_data, cyc, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_inverse();
`ifdef MIXCOL_INV_EN
      bit ok;
      int cyc;
      logic [127:0] e;
      send(V1_OUT, 1'b0, 1'b1, V1_IN, ok);
      wait_out(cyc);
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      n_cmp++; if (!ok || cyc != 4 || bus.out_data !== e) begin n_err++; $display("FAIL inverse: got %h lat %0d want %h lat 4", bus.out_data, cyc, e); end
      @(posedge clk); #1;
      send(V3, 1'b1, 1'b1, V3, ok);
      wait_out(cyc);
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      n_cmp++; if (!ok || cyc != 0 || bus.out_data !== e) begin n_err++; $display("FAIL inv_bypass: got %h lat %0d want %h lat 0", bus.out_data, cyc, e); end
      @(posedge clk); #1;
`endif
   endtask

   task automatic test_back_to_back();
      bit ok;
      int cyc;
      logic [127:0] d, e;
      logic last, inv, prev_norm;
      time t_prev, t_now;
      prev_norm = 1'b0;
      t_prev = 0;
      for (int i = 0; i < 6; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         last = (i == 3);
`ifdef MIXCOL_INV_EN
         inv = 1'($urandom_range(0, 1));
`else
         inv = 1'b0;
`endif
         send(d, last, inv, model(d, last, inv), ok);
         t_now = $time;
         if (prev_norm) begin
            n_cmp++; if (t_now - t_prev != 60) begin n_err++; $display("FAIL b2b_period[%0d]: got %0t want 60", i, t_now - t_prev); end
         end
         wait_out(cyc);
         e = exp_q.size() ? exp_q.pop_front() : 'x;
         n_cmp++;
         if (!ok || cyc != (last ? 0 : 4) || bus.out_data !== e) begin
            n_err++;
            $display("FAIL b2b_data[%0d]: got %h lat %0d want %h lat %0d", i, bus.out_data, cyc, e, last ? 0 : 4);
         end
         prev_norm = !last;
         t_prev = t_now;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_fips_cols();
      test_round1();
      test_bypass();
      test_backpressure();
      test_async_reset();
      test_inverse();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/aes_mixcol_seq.md
Name: aes_mixcol_seq

Overview:
- Sequential AES MixColumns stage sitting directly downstream of the combinational row-shift block; consumes its 128-bit rowshiftOut state word.
- Processes one 32-bit column per clock through a single shared GF(2^8) column datapath, keeping area low.
- Uses a valid/ready handshake on both sides.
- Supports final-round bypass, where AES skips MixColumns.

Parameters:
- COLS, 4, number of state columns processed; fixed at 4 for AES-128, sizes the column counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a state word.
- in_data  input  128  state from row-shift stage; column c = bits [127-32c -: 32], row 0 byte in the MSB of each column.
- in_last  input  1  final round: pass data through unchanged.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  MixColumns result, same byte layout as in_data.
- in_inv  input  1  inverse MixColumns select; present only when the optional macro is defined.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, column counter=0, captured flags=0.
  - Any in-flight block is discarded.
- FSM IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at edge E0: capture in_data into the work register, and capture in_last (and in_inv).
  - in_last=1 -> copy in_data to out_data, go to DONE.
  - Otherwise -> go to CALC with col=0.
- FSM CALC:
  - in_ready=0, out_valid=0.
  - Each edge computes column col from the work register: s'0=2s0^3s1^s2^s3, s'1=s0^2s1^3s2^s3, s'2=s0^s1^2s2^3s3, s'3=3s0^s1^s2^2s3.
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
  - The result is written into the corresponding out_data column; col increments.
  - After the edge that writes col=3 (E4) -> DONE; col wraps to 0.
- FSM DONE:
  - out_valid=1, in_ready=0, out_data stable.
  - On out_ready=1 at an edge -> IDLE; out_valid deasserts, out_data holds its last value.
- Latency, normal block: out_valid high in the cycle after E4, i.e. 4 cycles after the accept edge. Minimum period with out_ready held high is 6 cycles per block.
- Latency, bypass block: out_valid high in the cycle after E0.
- Backpressure: DONE holds indefinitely while out_ready=0; out_data must not change.
- in_valid while busy is ignored, since in_ready=0; upstream holds data.
- out_data columns not yet written during CALC are undefined to the consumer, because out_valid=0.
- out_ready asserted outside DONE has no effect.
- rst asserted mid-CALC or mid-DONE returns to IDLE immediately; the next accept starts a clean block.
- All GF arithmetic is 8-bit; no carries cross byte boundaries.

Optional Feature:
- Macro MIXCOL_INV_EN.
- Defined:
  - in_inv port exists and is captured at accept.
  - Captured in_inv=1 selects InvMixColumns coefficients {0E,0B,0D,09} in the rotating pattern s'0=E s0^B s1^D s2^9 s3, and so on, computed by chained xtime.
  - in_last bypass still takes priority over in_inv.
  - Latency is unchanged.
- Undefined:
  - No in_inv port; forward MixColumns only.
  - Inverse logic is not synthesised.

Test Plan:
- FIPS-197 columns:
  - Stimulus: in_data=128'hdb135345f20a225c01010101c6c6c6c6, in_last=0, out_ready=1.
  - Response: out_data=128'h8e4da1bc9fdc589d01010101c6c6c6c6; out_valid rises exactly 4 cycles after the accept edge and lasts 1 cycle.
- FIPS-197 round-1 state:
  - Stimulus: in_data=128'hd4bf5d30e0b452aeb84111f11e2798e5.
  - Response: out_data=128'h046681e5e0cb199a48f8d37a2806264c.
- Final-round bypass:
  - Stimulus: in_data=128'h000102030405060708090A0B0C0D0E0F, in_last=1.
  - Response: out_data equals the input; out_valid high the cycle after accept.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid, with in_valid held high carrying new data.
  - Response: out_valid stays 1, out_data stable, in_ready=0. On out_ready=1, IDLE is re-entered and the second block is then accepted.
- Async reset mid-CALC:
  - Stimulus: assert rst 2 cycles after accept, between edges.
  - Response: out_valid=0, out_data=0, in_ready=1 immediately. A following block (vector from the FIPS-197 columns scenario) completes correctly.
- MIXCOL_INV_EN defined:
  - Stimulus: in_data=128'h8e4da1bc9fdc589d01010101c6c6c6c6, in_inv=1.
  - Response: out_data=128'hdb135345f20a225c01010101c6c6c6c6.
